// File: rtl/tt_um_dev_parity_frame_tx.sv
// Odd-parity 3-bit frame transmitter (d1, d0, P) fed by a small FIFO.
// Frames go out back-to-back, one bit per clock, in the TinyTapeout tile slot.
module tt_um_dev_parity_frame_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B1   = 2'd1,
    B2   = 2'd2,
    B3   = 2'd3
  } txState_t;

  txState_t         state_q, state_d;
  logic [2:0]       fifoMem [FIFO_DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [AW:0]      count_q, count_d;
  logic [2:0]       frame_q, frame_d;
  logic             txBit_q, txBit_d;
  logic             frameStart_q, frameStart_d;
  logic             busy_q, busy_d;
  logic             fifoFull_q, fifoFull_d;
  logic             fifoEmpty_q, fifoEmpty_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] frameCnt_q, frameCnt_d;

  logic       pushReq;
  logic       pushOk;
  logic       popOk;
  logic       fifoIsFull;
  logic [2:0] headEntry;
  logic       unusedBits;

  assign pushReq    = ui_in[2];
  assign fifoIsFull = (count_q == DEPTH_C);
  assign pushOk     = pushReq && !fifoIsFull;
  assign popOk      = ((state_q == IDLE) || (state_q == B3)) && (count_q != '0);
  assign headEntry  = fifoMem[rdPtr_q];
  assign unusedBits = &{1'b0, ena, ui_in[7:4], uio_in};

  // Full/empty judged on pre-edge occupancy, so a same-edge pop never frees room.
  always_comb begin
    count_d = count_q;
    case ({pushOk, popOk})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    txBit_d      = txBit_q;
    frameStart_d = 1'b0;
    case (state_q)
      IDLE, B3: begin
        if (popOk) begin
          state_d      = B1;
          frame_d      = headEntry;
          txBit_d      = headEntry[1];
          frameStart_d = 1'b1;
        end else begin
          state_d = IDLE;
          txBit_d = 1'b0;
        end
      end
      B1: begin
        state_d = B2;
        txBit_d = frame_q[0];
      end
      B2: begin
        state_d = B3;
        txBit_d = ~(frame_q[1] ^ frame_q[0]) ^ frame_q[2];
      end
      default: begin
        state_d = IDLE;
        txBit_d = 1'b0;
      end
    endcase
    busy_d      = (state_d != IDLE);
    fifoFull_d  = (count_d == DEPTH_C);
    fifoEmpty_d = (count_d == '0);
    overflow_d  = overflow_q || (pushReq && fifoIsFull);
    frameCnt_d  = (state_q == B3) ? frameCnt_q + CNT_W'(1) : frameCnt_q;
  end

  always_ff @(posedge clk) begin
    if (pushOk) begin
      fifoMem[wrPtr_q] <= {ui_in[3], ui_in[1:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      count_q      <= '0;
      frame_q      <= '0;
      txBit_q      <= 1'b0;
      frameStart_q <= 1'b0;
      busy_q       <= 1'b0;
      fifoFull_q   <= 1'b0;
      fifoEmpty_q  <= 1'b1;
      overflow_q   <= 1'b0;
      frameCnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      wrPtr_q      <= pushOk ? wrPtr_q + AW'(1) : wrPtr_q;
      rdPtr_q      <= popOk ? rdPtr_q + AW'(1) : rdPtr_q;
      count_q      <= count_d;
      frame_q      <= frame_d;
      txBit_q      <= txBit_d;
      frameStart_q <= frameStart_d;
      busy_q       <= busy_d;
      fifoFull_q   <= fifoFull_d;
      fifoEmpty_q  <= fifoEmpty_d;
      overflow_q   <= overflow_d;
      frameCnt_q   <= frameCnt_d;
    end
  end

  assign uo_out  = {2'b00, overflow_q, fifoEmpty_q, fifoFull_q, busy_q, frameStart_q, txBit_q};
  assign uio_out = 8'(frameCnt_q);
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_dev_parity_frame_tx.sv
// Scoreboard bench for the parity frame transmitter: accepted words queue an
// expected frame, which is popped and compared when the DUT raises frame_start.
module tb_tt_um_dev_parity_frame_tx;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_dev_parity_frame_tx #(.FIFO_DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  int         testsRun;
  int         testsFailed;
  logic [2:0] expQ[$];
  logic [2:0] curFrame;
  int         mCount;
  int         mPhase;
  logic [7:0] mFrames;
  logic       mOverflow;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    testsRun++;
    if (got !== want) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic modelReset();
    expQ.delete();
    curFrame  = '0;
    mCount    = 0;
    mPhase    = 0;
    mFrames   = '0;
    mOverflow = 1'b0;
  endtask

  // Called away from the rising edge; the line bit comes from the scoreboard frame.
  task automatic sampleOutputs();
    logic expTx;
    checkOutput("busy", 32'(uo_out[2]), 32'(mPhase != 0));
    checkOutput("frameStart", 32'(uo_out[1]), 32'(mPhase == 1));
    if (uo_out[1] === 1'b1) begin
      checkOutput("sbPending", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) curFrame = expQ.pop_front();
    end
    case (mPhase)
      1:       expTx = curFrame[2];
      2:       expTx = curFrame[1];
      3:       expTx = curFrame[0];
      default: expTx = 1'b0;
    endcase
    checkOutput("txBit", 32'(uo_out[0]), 32'(expTx));
    checkOutput("fifoFull", 32'(uo_out[3]), 32'(mCount == DEPTH));
    checkOutput("fifoEmpty", 32'(uo_out[4]), 32'(mCount == 0));
    checkOutput("overflow", 32'(uo_out[5]), 32'(mOverflow));
    checkOutput("uoHigh", 32'(uo_out[7:6]), 32'd0);
    checkOutput("frameCount", 32'(uio_out), 32'(mFrames));
    checkOutput("uioOe", 32'(uio_oe), 32'hFF);
  endtask

  task automatic applyStimulus(input logic push, input logic [1:0] data, input logic err);
    logic accept;
    logic popNow;
    ui_in  = {4'b0000, err, push, data};
    accept = push && (mCount < DEPTH);
    popNow = ((mPhase == 0) || (mPhase == 3)) && (mCount > 0);
    if (accept) expQ.push_back({data[1], data[0], ~(data[1] ^ data[0]) ^ err});
    if (push && !accept) mOverflow = 1'b1;
    mCount = mCount + int'(accept) - int'(popNow);
    if (mPhase == 3) mFrames = mFrames + 8'd1;
    if (popNow)           mPhase = 1;
    else if (mPhase == 1) mPhase = 2;
    else if (mPhase == 2) mPhase = 3;
    else                  mPhase = 0;
    @(posedge clk);
    @(negedge clk);
    sampleOutputs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    modelReset();
    repeat (2) @(negedge clk);
    sampleOutputs();
    rst_n = 1'b1;
    idle(2);

    $display("[TB] single frame 00");
    applyStimulus(1'b1, 2'b00, 1'b0);
    idle(6);

    $display("[TB] back-to-back 01 10 11");
    applyStimulus(1'b1, 2'b01, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b0);
    applyStimulus(1'b1, 2'b11, 1'b0);
    idle(12);

    $display("[TB] injected parity error on 10");
    applyStimulus(1'b1, 2'b10, 1'b1);
    idle(6);

    $display("[TB] push held 8 clocks");
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 2'(i), 1'(i >> 2));
    idle(30);

    $display("[TB] reset during B2");
    applyStimulus(1'b1, 2'b11, 1'b0);
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    sampleOutputs();
    @(negedge clk);
    sampleOutputs();
    rst_n = 1'b1;
    idle(5);

    $display("[TB] 256 frames to wrap the counter");
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 2'(i), 1'b0);
      idle(2);
    end
    idle(6);
    checkOutput("wrapCount", 32'(uio_out), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/tt_um_dev_parity_frame_tx.md
Name: tt_um_dev_parity_frame_tx

Overview:
- Serial transmitter for the 3-bit odd-parity frame protocol that our Mealy frame checker receives.
- Accepts 2-bit data words through a small FIFO and serializes each word as d1, d0, P with P = ~(d1 ^ d0), so every frame has odd parity.
- Frames go out back-to-back with no gap, one bit per clock, while data is queued.
- Drops into the same TinyTapeout user-tile slot. uo_out[0] connects directly to the checker's serial input.

Parameters:
- FIFO_DEPTH, 4, number of queued frames; power of two, >= 2.
- CNT_W, 8, width of the completed-frame counter (drives uio_out).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- ena  input  1  tile enable; always 1, ignored
- ui_in  input  8  [1:0] data word (d1 = bit1); [2] push; [3] inject_err; [7:4] unused
- uo_out  output  8  [0] tx_bit; [1] frame_start; [2] busy; [3] fifo_full; [4] fifo_empty; [5] overflow; [7:6] 0
- uio_in  input  8  unused
- uio_out  output  8  completed-frame count
- uio_oe  output  8  constant 8'hFF

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. All state is flopped.
- Reset values:
  - FSM = IDLE; FIFO empty, pointers 0.
  - tx_bit = 0, frame_start = 0, busy = 0, fifo_full = 0, fifo_empty = 1, overflow = 0.
  - Frame count = 0.
- Reset asserted mid-frame aborts the frame at once. The line returns to the reset values with no clock needed.
- Push:
  - push (ui_in[2]) is level-sampled at each rising edge. While high, one entry is written per clock.
  - Entry = {inject_err, ui_in[1:0]}, captured at that edge.
  - Push accepted only if the FIFO was not full before the edge.
  - A same-edge pop does not free space for a push on a full FIFO. That push is dropped and overflow is set.
  - overflow is sticky; only reset clears it.
- No bypass: a word pushed into an empty FIFO is popped no earlier than the following edge.
- FSM states: IDLE, B1, B2, B3.
  - IDLE or B3, FIFO non-empty: pop the head → B1; tx_bit <= d1; frame_start <= 1.
  - IDLE or B3, FIFO empty: → IDLE; tx_bit <= 0; frame_start <= 0.
  - B1 → B2: tx_bit <= d0; frame_start <= 0.
  - B2 → B3: tx_bit <= P ^ inject_err, with P = ~(d1 ^ d0).
- Frame counter increments on every edge that leaves B3, wrapping to 0 after 2^CNT_W - 1.
- Outputs:
  - All outputs are registered.
  - busy = 1 in B1/B2/B3, marking valid line bits.
  - frame_start marks bit 1 of each frame.
- Latency: a push accepted at edge E into an empty, idle block puts d1 on tx_bit after edge E+1.
- Throughput: continuous pushes give back-to-back frames, 3 clocks per frame. Line bits: d1 d0 P d1 d0 P ...
- Simultaneous push and pop on a non-full FIFO: both happen; occupancy unchanged.
- Unused inputs are tied off into an unused-wire reduction. uo_out[7:6] = 0.

Test Plan:
- Reset, then push 2'b00 for one clock → after 1-cycle latency tx_bit = 0,0,1; frame_start high on bit 1 only; busy high 3 cycles; uio_out = 1; then IDLE with tx_bit = 0.
- Push 01, 10, 11 on consecutive clocks → 9 contiguous line bits 0,1,0, 1,0,0, 1,1,1; busy never drops; uio_out = 3; the checker's output pulses on each third bit.
- Push 2'b10 with inject_err = 1 → line bits 1,0,1 (even parity); the checker flags no frame; uio_out still increments.
- Hold push high for 8 clocks starting from idle → FIFO fills; fifo_full asserts; later pushes are dropped; overflow = 1 and stays set; exactly the accepted frames are transmitted.
- Deassert rst_n mid-B2 → tx_bit, busy and uio_out go to 0 asynchronously; fifo_empty = 1; after release the line stays idle until a new push.
- Preload the counter near wrap: transmit 256 frames → uio_out wraps 255 → 0 on the edge leaving B3.
